idma_burst_gen: RTL and testbench

- Upstream feeder of the AXI 4K-cross address stage in the iDMA data NoC path.
- Accepts one transfer command (32-byte-aligned start address, length in 256-bit beats) and chops it into AXI INCR bursts of at most 16 beats.
- Presents each burst on the dma_trans_burst_* interface and retires it on dma_xaddr_burst_ok.
- Tracks outstanding bursts until their data completes (axi_burst_xdata_ok), then pulses done.

---
 rtl/idma_pkg.sv | 16 +
 rtl/idma_burst_size_calc.sv | 30 +++
 rtl/idma_burst_gen.sv | 123 ++++++++++++
 tb/tb_idma_burst_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_pkg.sv
// Shared constants and types for the iDMA burst generator.
// Beat geometry, page size and FSM state encoding.
package idma_pkg;

  localparam int BEAT_BYTES      = 32;
  localparam int BEAT_SHIFT      = 5;
  localparam int MAX_BURST_BEATS = 16;
  localparam int PAGE_BEATS      = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/idma_burst_size_calc.sv
// Combinational burst sizing: beats in the next burst and its AXI len.
// Limited by remaining beats, the 16-beat cap and optionally the 4KB page.
module idma_burst_size_calc
  import idma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [6:0]       page_idx_i,
  input  logic [LEN_W-1:0] rem_beats_i,
  input  logic             split_i,
  output logic [4:0]       nb_o,
  output logic [3:0]       len_o
);

  logic [7:0] to4k;
  logic [4:0] cap;

  always_comb begin
    to4k = 8'(PAGE_BEATS) - {1'b0, page_idx_i};
    cap  = 5'(MAX_BURST_BEATS);
    if (split_i && (to4k < 8'(MAX_BURST_BEATS)))
      cap = to4k[4:0];
    nb_o = cap;
    if (rem_beats_i < LEN_W'(cap))
      nb_o = rem_beats_i[4:0];
    // an empty remainder reports len 0 rather than wrapping to 15
    len_o = (nb_o == 5'd0) ? 4'd0 : (nb_o[3:0] - 4'd1);
  end

endmodule

// File: rtl/idma_burst_gen.sv
// Chops one transfer command into AXI INCR bursts of up to 16 beats
// and tracks outstanding bursts until their data phase completes.
module idma_burst_gen
  import idma_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_beats,
  input  logic             cfg_split4k,
  output logic             dma_trans_burst_avalid,
  output logic [31:0]      dma_trans_burst_addr,
  output logic [3:0]       dma_trans_burst_len,
  input  logic             dma_xaddr_burst_ok,
  input  logic             axi_burst_xdata_ok,
  output logic             busy,
  output logic             done,
  output logic [3:0]       outst_cnt,
  output logic             err_underflow
);

  state_e           state_q, state_d;
  logic [26:0]      cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             split_q, split_d;
  logic [3:0]       outst_q, outst_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [4:0]       nb;
  logic             burst_acc;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[BEAT_SHIFT-1:0];

  idma_burst_size_calc #(
    .LEN_W(LEN_W)
  ) u_size (
    .page_idx_i  (cur_addr_q[6:0]),
    .rem_beats_i (rem_q),
    .split_i     (split_q),
    .nb_o        (nb),
    .len_o       (dma_trans_burst_len)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    split_d    = split_q;
    outst_d    = outst_q;
    err_d      = err_q;
    done_d     = 1'b0;
    // hold off a new command during the done pulse
    cmd_ready  = (state_q == IDLE) && !done_q;
    dma_trans_burst_avalid =
      (state_q == ISSUE) && (outst_q < 4'(MAX_OUTST));
    burst_acc = dma_trans_burst_avalid && dma_xaddr_burst_ok;

    if (burst_acc && !axi_burst_xdata_ok)
      outst_d = outst_q + 4'd1;
    else if (!burst_acc && axi_burst_xdata_ok) begin
      if (outst_q == 4'd0) err_d = 1'b1;
      else outst_d = outst_q - 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d = cmd_addr[31:BEAT_SHIFT];
          rem_d      = cmd_beats;
          split_d    = cfg_split4k;
          state_d    = (cmd_beats == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (burst_acc) begin
          cur_addr_d = cur_addr_q + 27'(nb);
          rem_d      = rem_q - LEN_W'(nb);
          if (rem_q == LEN_W'(nb)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_d == 4'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      split_q    <= 1'b0;
      outst_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      split_q    <= split_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign dma_trans_burst_addr = {cur_addr_q, 5'b0};
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign outst_cnt     = outst_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_idma_burst_gen.sv
// Directed bench for idma_burst_gen: default instance plus a
// MAX_OUTST=2 instance sharing the same stimulus.
module tb_idma_burst_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        split;
  logic        ok;
  logic        xdata;

  logic        rdy, av, bz, dn, er;
  logic [31:0] ba;
  logic [3:0]  bl, oc;
  logic        rdy2, av2, bz2, dn2, er2;
  logic [31:0] ba2;
  logic [3:0]  bl2, oc2;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] b_addr [8];
  logic [3:0]  b_len  [8];
  int          nburst, ndone, peak;

  always #5 clk = ~clk;

  idma_burst_gen u_dut (
    .aclk                   (clk),
    .areset                 (areset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (rdy),
    .cmd_addr               (cmd_addr),
    .cmd_beats              (cmd_beats),
    .cfg_split4k            (split),
    .dma_trans_burst_avalid (av),
    .dma_trans_burst_addr   (ba),
    .dma_trans_burst_len    (bl),
    .dma_xaddr_burst_ok     (ok),
    .axi_burst_xdata_ok     (xdata),
    .busy                   (bz),
    .done                   (dn),
    .outst_cnt              (oc),
    .err_underflow          (er)
  );

  idma_burst_gen #(.LEN_W(16), .MAX_OUTST(2)) u_dut2 (
    .aclk                   (clk),
    .areset                 (areset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (rdy2),
    .cmd_addr               (cmd_addr),
    .cmd_beats              (cmd_beats),
    .cfg_split4k            (split),
    .dma_trans_burst_avalid (av2),
    .dma_trans_burst_addr   (ba2),
    .dma_trans_burst_len    (bl2),
    .dma_xaddr_burst_ok     (ok),
    .axi_burst_xdata_ok     (xdata),
    .busy                   (bz2),
    .done                   (dn2),
    .outst_cnt              (oc2),
    .err_underflow          (er2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  // ok held high; each accepted burst completes its data 3 cycles later
  task automatic run_xfer(input logic [31:0] a,
                          input logic [15:0] n,
                          input logic s);
    logic [3:0] sr;
    int tail;
    sr = '0;
    nburst = 0;
    ndone = 0;
    peak = 0;
    tail = 0;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_beats = n;
    split = s;
    ok = 1'b1;
    xdata = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_avalid", 32'(av), 32'd1);
    for (int c = 0; c < 60 && tail < 4; c++) begin
      if (av && ok) begin
        if (nburst < 8) begin
          b_addr[nburst] = ba;
          b_len[nburst] = bl;
        end
        nburst++;
      end
      if (dn) ndone++;
      if (ndone > 0) tail++;
      if (int'(oc) > peak) peak = int'(oc);
      sr = {sr[2:0], av && ok};
      xdata = sr[3];
      @(negedge clk);
    end
    ok = 1'b0;
    xdata = 1'b0;
    chk("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    areset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    split = 1'b0;
    ok = 1'b0;
    xdata = 1'b0;
    do_reset();

    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_avalid", 32'(av), 32'd0);
    chk("rst_addr", ba, 32'd0);
    chk("rst_len", 32'(bl), 32'd0);
    chk("rst_busy", 32'(bz), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    chk("rst_outst", 32'(oc), 32'd0);
    chk("rst_err", 32'(er), 32'd0);

    run_xfer(32'h1000, 16'd40, 1'b1);
    chk("t1_nburst", 32'(nburst), 32'd3);
    chk("t1_addr0", b_addr[0], 32'h1000);
    chk("t1_len0", 32'(b_len[0]), 32'd15);
    chk("t1_addr1", b_addr[1], 32'h1200);
    chk("t1_len1", 32'(b_len[1]), 32'd15);
    chk("t1_addr2", b_addr[2], 32'h1400);
    chk("t1_len2", 32'(b_len[2]), 32'd7);
    chk("t1_peak", 32'(peak), 32'd3);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_idle", 32'(bz), 32'd0);

    run_xfer(32'h1F80, 16'd16, 1'b1);
    chk("t2s_nburst", 32'(nburst), 32'd2);
    chk("t2s_addr0", b_addr[0], 32'h1F80);
    chk("t2s_len0", 32'(b_len[0]), 32'd3);
    chk("t2s_addr1", b_addr[1], 32'h2000);
    chk("t2s_len1", 32'(b_len[1]), 32'd11);

    run_xfer(32'h1F9F, 16'd16, 1'b0);
    chk("t2n_nburst", 32'(nburst), 32'd1);
    chk("t2n_addr0", b_addr[0], 32'h1F80);
    chk("t2n_len0", 32'(b_len[0]), 32'd15);

    // outstanding limit on the MAX_OUTST=2 instance
    do_reset();
    cmd_valid = 1'b1;
    cmd_addr = 32'h4000;
    cmd_beats = 16'd128;
    split = 1'b0;
    ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("m_av0", 32'(av2), 32'd1);
    chk("m_addr0", ba2, 32'h4000);
    @(negedge clk);
    chk("m_av1", 32'(av2), 32'd1);
    chk("m_addr1", ba2, 32'h4200);
    @(negedge clk);
    chk("m_av_drop", 32'(av2), 32'd0);
    chk("m_outst2", 32'(oc2), 32'd2);
    @(negedge clk);
    chk("m_av_hold", 32'(av2), 32'd0);
    xdata = 1'b1;
    @(negedge clk);
    chk("m_av_back", 32'(av2), 32'd1);
    chk("m_addr2", ba2, 32'h4400);
    chk("m_outst1", 32'(oc2), 32'd1);
    xdata = 1'b1;
    @(negedge clk);
    xdata = 1'b0;
    chk("both_outst", 32'(oc2), 32'd1);
    chk("both_addr", ba2, 32'h4600);
    chk("both_err", 32'(er2), 32'd0);
    @(negedge clk);
    chk("pre_rst_outst", 32'(oc2), 32'd2);
    chk("pre_rst_busy", 32'(bz2), 32'd1);
    ok = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    chk("mr_ready", 32'(rdy2), 32'd1);
    chk("mr_avalid", 32'(av2), 32'd0);
    chk("mr_addr", ba2, 32'd0);
    chk("mr_len", 32'(bl2), 32'd0);
    chk("mr_busy", 32'(bz2), 32'd0);
    chk("mr_done", 32'(dn2), 32'd0);
    chk("mr_outst", 32'(oc2), 32'd0);
    chk("mr_err", 32'(er2), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dn2) seen++;
    end
    chk("mr_no_done", 32'(seen), 32'd0);

    // zero-length command
    cmd_valid = 1'b1;
    cmd_addr = 32'h8000;
    cmd_beats = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("z_busy", 32'(bz), 32'd1);
    chk("z_done1", 32'(dn), 32'd0);
    chk("z_av1", 32'(av), 32'd0);
    @(negedge clk);
    chk("z_done2", 32'(dn), 32'd1);
    chk("z_av2", 32'(av), 32'd0);
    chk("z_ready_gap", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("z_done3", 32'(dn), 32'd0);
    chk("z_ready", 32'(rdy), 32'd1);

    // stray data completion in IDLE
    xdata = 1'b1;
    @(negedge clk);
    xdata = 1'b0;
    chk("uf_set", 32'(er), 32'd1);
    chk("uf_outst", 32'(oc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("uf_sticky", 32'(er), 32'd1);
    do_reset();
    chk("uf_clear", 32'(er), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
